// File: rtl/ibuffer_if.sv
// Decode-to-issue instruction buffer bus.
// Decode and scheduler act as master; the buffer is the slave.
interface ibuffer_if #(
    parameter int ENTRY_W = 77
);
    logic [7:0]         Valid_ID0_IB;
    logic [7:0]         Valid_ID1_IB;
    logic [ENTRY_W-1:0] Entry_ID0_IB;
    logic [ENTRY_W-1:0] Entry_ID1_IB;
    logic [7:0]         Flush_SIMT_IB;
    logic [7:0]         Issue_Grant;
    logic [7:0]         Head_Valid;
    logic [ENTRY_W-1:0] Issue_Entry;
    logic               Issue_Valid;
    logic [7:0]         Full_IB_IF;
    logic               Overflow_Err;

    modport master (
        output Valid_ID0_IB, Valid_ID1_IB,
        output Entry_ID0_IB, Entry_ID1_IB,
        output Flush_SIMT_IB, Issue_Grant,
        input  Head_Valid, Issue_Entry, Issue_Valid,
        input  Full_IB_IF, Overflow_Err
    );

    modport slave (
        input  Valid_ID0_IB, Valid_ID1_IB,
        input  Entry_ID0_IB, Entry_ID1_IB,
        input  Flush_SIMT_IB, Issue_Grant,
        output Head_Valid, Issue_Entry, Issue_Valid,
        output Full_IB_IF, Overflow_Err
    );
endinterface

// File: rtl/ibuffer.sv
// Per-warp instruction buffer: eight circular FIFOs fed by two
// decode lanes and drained by a one-hot scheduler grant.
module ibuffer #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 77
) (
    input  logic      clk,
    input  logic      rst_n,
    ibuffer_if.slave  bus
);
    localparam int NW = 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [ENTRY_W-1:0] entry_t;

    entry_t        mem_q [NW][DEPTH];
    logic [PW-1:0] rptr_q [NW];
    logic [PW-1:0] rptr_d [NW];
    logic [PW-1:0] wptr_q [NW];
    logic [PW-1:0] wptr_d [NW];
    logic [PW-1:0] addr1  [NW];
    logic [CW-1:0] cnt_q  [NW];
    logic [CW-1:0] cnt_d  [NW];
    logic [CW-1:0] room   [NW];
    logic          ovf_q;
    logic          ovf_d;

    logic [NW-1:0] deq;
    logic [NW-1:0] we0;
    logic [NW-1:0] we1;
    logic [NW-1:0] drop;
    logic [2:0]    gsel;
    logic          gany;

    // Lowest-index grant wins; scan from the top so the last hit is lowest.
    always_comb begin
        gsel = '0;
        gany = 1'b0;
        for (int w = NW - 1; w >= 0; w--) begin
            if (bus.Issue_Grant[w]) begin
                gsel = 3'(w);
                gany = 1'b1;
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NW; w++) begin
            deq[w] = gany && (gsel == 3'(w)) && (cnt_q[w] != '0);
        end
    end

    // Room counts the slot freed by a same-cycle dequeue.
    always_comb begin
        ovf_d = ovf_q;
        for (int w = 0; w < NW; w++) begin
            room[w]  = CW'(DEPTH) - cnt_q[w] + CW'(deq[w]);
            we0[w]   = bus.Valid_ID0_IB[w] && !bus.Flush_SIMT_IB[w]
                       && (room[w] != '0);
            we1[w]   = bus.Valid_ID1_IB[w] && !bus.Flush_SIMT_IB[w]
                       && (we0[w] ? (room[w] >= CW'(2))
                                  : (room[w] != '0));
            drop[w]  = !bus.Flush_SIMT_IB[w]
                       && ((bus.Valid_ID0_IB[w] && !we0[w])
                        || (bus.Valid_ID1_IB[w] && !we1[w]));
            addr1[w] = wptr_q[w] + PW'(we0[w]);
            if (bus.Flush_SIMT_IB[w]) begin
                cnt_d[w]  = '0;
                rptr_d[w] = '0;
                wptr_d[w] = '0;
            end else begin
                cnt_d[w]  = cnt_q[w] - CW'(deq[w])
                            + CW'(we0[w]) + CW'(we1[w]);
                rptr_d[w] = rptr_q[w] + PW'(deq[w]);
                wptr_d[w] = wptr_q[w] + PW'(we0[w]) + PW'(we1[w]);
            end
        end
        if (|drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NW; w++) begin
                cnt_q[w]  <= '0;
                rptr_q[w] <= '0;
                wptr_q[w] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                cnt_q[w]  <= cnt_d[w];
                rptr_q[w] <= rptr_d[w];
                wptr_q[w] <= wptr_d[w];
            end
            ovf_q <= ovf_d;
        end
    end

    // Storage is not reset; counts and pointers alone define validity.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (we0[w]) begin
                mem_q[w][wptr_q[w]] <= bus.Entry_ID0_IB;
            end
            if (we1[w]) begin
                mem_q[w][addr1[w]] <= bus.Entry_ID1_IB;
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NW; w++) begin
            bus.Head_Valid[w] = (cnt_q[w] != '0);
            bus.Full_IB_IF[w] = (cnt_q[w] >= CW'(DEPTH - 1));
        end
    end

    assign bus.Issue_Valid  = |deq;
    assign bus.Issue_Entry  = (|deq) ? mem_q[gsel][rptr_q[gsel]] : '0;
    assign bus.Overflow_Err = ovf_q;

endmodule

// File: tb/tb_ibuffer.sv
// Directed scenario bench for the per-warp instruction buffer.
// Inputs change 1ns after the rising edge; outputs are read mid-cycle.
module tb_ibuffer;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    ibuffer_if #(.ENTRY_W(77)) bus ();

    ibuffer #(.DEPTH(4), .ENTRY_W(77)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [76:0] mk(input logic [31:0] i);
        return {13'h1ABC, ~i, i};
    endfunction

    task automatic idle();
        bus.Valid_ID0_IB  = '0;
        bus.Valid_ID1_IB  = '0;
        bus.Entry_ID0_IB  = '0;
        bus.Entry_ID1_IB  = '0;
        bus.Flush_SIMT_IB = '0;
        bus.Issue_Grant   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.Issue_Grant = 8'hFF;
        #12;
        n_total++;
        if (bus.Head_Valid !== 8'h00)
            $display("FAIL reset_head got=%h exp=00", bus.Head_Valid);
        else n_pass++;
        n_total++;
        if (bus.Full_IB_IF !== 8'h00)
            $display("FAIL reset_full got=%h exp=00", bus.Full_IB_IF);
        else n_pass++;
        n_total++;
        if (bus.Issue_Valid !== 1'b0 || bus.Issue_Entry !== 77'd0)
            $display("FAIL reset_issue got=%b/%h exp=0/0",
                     bus.Issue_Valid, bus.Issue_Entry);
        else n_pass++;
        n_total++;
        if (bus.Overflow_Err !== 1'b0)
            $display("FAIL reset_ovf got=%b exp=0", bus.Overflow_Err);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        #1;
    endtask

    task automatic test_basic();
        bus.Valid_ID0_IB = 8'h04;
        bus.Entry_ID0_IB = mk(32'h20010005);
        #1;
        n_total++;
        if (bus.Head_Valid !== 8'h00)
            $display("FAIL basic_nobypass got=%h exp=00", bus.Head_Valid);
        else n_pass++;
        step();
        n_total++;
        if (bus.Head_Valid !== 8'h04)
            $display("FAIL basic_head got=%h exp=04", bus.Head_Valid);
        else n_pass++;
        bus.Issue_Grant = 8'h04;
        #1;
        n_total++;
        if (bus.Issue_Valid !== 1'b1 ||
            bus.Issue_Entry[31:0] !== 32'h20010005)
            $display("FAIL basic_issue got=%b/%h exp=1/20010005",
                     bus.Issue_Valid, bus.Issue_Entry[31:0]);
        else n_pass++;
        n_total++;
        if (bus.Issue_Entry !== mk(32'h20010005))
            $display("FAIL basic_entry got=%h exp=%h",
                     bus.Issue_Entry, mk(32'h20010005));
        else n_pass++;
        step();
        n_total++;
        if (bus.Head_Valid !== 8'h00)
            $display("FAIL basic_empty got=%h exp=00", bus.Head_Valid);
        else n_pass++;
    endtask

    task automatic test_dual_lane();
        bus.Valid_ID0_IB = 8'h20;
        bus.Valid_ID1_IB = 8'h20;
        bus.Entry_ID0_IB = mk(32'hAAAA0001);
        bus.Entry_ID1_IB = mk(32'hBBBB0002);
        step();
        n_total++;
        if (bus.Head_Valid !== 8'h20 || bus.Full_IB_IF[5] !== 1'b0)
            $display("FAIL dual_head got=%h/%b exp=20/0",
                     bus.Head_Valid, bus.Full_IB_IF[5]);
        else n_pass++;
        bus.Issue_Grant = 8'h20;
        #1;
        n_total++;
        if (bus.Issue_Entry !== mk(32'hAAAA0001))
            $display("FAIL dual_first got=%h exp=%h",
                     bus.Issue_Entry, mk(32'hAAAA0001));
        else n_pass++;
        step();
        bus.Issue_Grant = 8'h20;
        #1;
        n_total++;
        if (bus.Issue_Entry !== mk(32'hBBBB0002) ||
            bus.Full_IB_IF[5] !== 1'b0)
            $display("FAIL dual_second got=%h exp=%h",
                     bus.Issue_Entry, mk(32'hBBBB0002));
        else n_pass++;
        step();
        n_total++;
        if (bus.Head_Valid !== 8'h00)
            $display("FAIL dual_empty got=%h exp=00", bus.Head_Valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        bus.Valid_ID0_IB = 8'h08;
        bus.Valid_ID1_IB = 8'h08;
        bus.Entry_ID0_IB = mk(32'h33330001);
        bus.Entry_ID1_IB = mk(32'h33330002);
        step();
        n_total++;
        if (bus.Head_Valid !== 8'h08)
            $display("FAIL flush_pre got=%h exp=08", bus.Head_Valid);
        else n_pass++;
        bus.Flush_SIMT_IB = 8'h08;
        bus.Valid_ID0_IB  = 8'h08;
        bus.Entry_ID0_IB  = mk(32'h33330003);
        bus.Issue_Grant   = 8'h08;
        #1;
        n_total++;
        if (bus.Issue_Valid !== 1'b1)
            $display("FAIL flush_issue got=%b exp=1", bus.Issue_Valid);
        else n_pass++;
        step();
        n_total++;
        if (bus.Head_Valid !== 8'h00 || bus.Overflow_Err !== 1'b0)
            $display("FAIL flush_post got=%h/%b exp=00/0",
                     bus.Head_Valid, bus.Overflow_Err);
        else n_pass++;
        step();
        n_total++;
        if (bus.Head_Valid !== 8'h00)
            $display("FAIL flush_lost got=%h exp=00", bus.Head_Valid);
        else n_pass++;
    endtask

    task automatic test_grant_priority();
        bus.Valid_ID0_IB = 8'h10;
        bus.Valid_ID1_IB = 8'h80;
        bus.Entry_ID0_IB = mk(32'h44440004);
        bus.Entry_ID1_IB = mk(32'h77770007);
        step();
        bus.Issue_Grant = 8'h90;
        #1;
        n_total++;
        if (bus.Issue_Valid !== 1'b1 ||
            bus.Issue_Entry !== mk(32'h44440004))
            $display("FAIL prio_pick got=%b/%h exp=1/%h", bus.Issue_Valid,
                     bus.Issue_Entry, mk(32'h44440004));
        else n_pass++;
        step();
        n_total++;
        if (bus.Head_Valid !== 8'h80)
            $display("FAIL prio_head got=%h exp=80", bus.Head_Valid);
        else n_pass++;
        bus.Issue_Grant = 8'h02;
        #1;
        n_total++;
        if (bus.Issue_Valid !== 1'b0 || bus.Issue_Entry !== 77'd0)
            $display("FAIL prio_empty got=%b/%h exp=0/0",
                     bus.Issue_Valid, bus.Issue_Entry);
        else n_pass++;
        step();
        bus.Issue_Grant = 8'h80;
        #1;
        n_total++;
        if (bus.Issue_Entry !== mk(32'h77770007))
            $display("FAIL prio_w7 got=%h exp=%h",
                     bus.Issue_Entry, mk(32'h77770007));
        else n_pass++;
        step();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_q [4];
        exp_q = '{32'h2, 32'h3, 32'h4, 32'h6};
        for (int i = 1; i <= 3; i++) begin
            bus.Valid_ID0_IB = 8'h01;
            bus.Entry_ID0_IB = mk(32'(i));
            step();
        end
        n_total++;
        if (bus.Full_IB_IF !== 8'h01 || bus.Overflow_Err !== 1'b0)
            $display("FAIL ovf_full3 got=%h/%b exp=01/0",
                     bus.Full_IB_IF, bus.Overflow_Err);
        else n_pass++;
        bus.Valid_ID0_IB = 8'h01;
        bus.Entry_ID0_IB = mk(32'h4);
        step();
        bus.Valid_ID0_IB = 8'h01;
        bus.Entry_ID0_IB = mk(32'h5);
        step();
        n_total++;
        if (bus.Overflow_Err !== 1'b1)
            $display("FAIL ovf_drop got=%b exp=1", bus.Overflow_Err);
        else n_pass++;
        bus.Valid_ID0_IB = 8'h01;
        bus.Entry_ID0_IB = mk(32'h6);
        bus.Issue_Grant  = 8'h01;
        #1;
        n_total++;
        if (bus.Issue_Entry !== mk(32'h1))
            $display("FAIL ovf_head got=%h exp=%h",
                     bus.Issue_Entry, mk(32'h1));
        else n_pass++;
        step();
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (bus.Full_IB_IF[0] !== 1'b1 && i < 2)
                $display("FAIL ovf_stall%0d got=0 exp=1", i);
            else if (i < 2) n_pass++;
            else n_total--;
            bus.Issue_Grant = 8'h01;
            #1;
            n_total++;
            if (bus.Issue_Valid !== 1'b1 ||
                bus.Issue_Entry !== mk(exp_q[i]))
                $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i,
                         bus.Issue_Valid, bus.Issue_Entry, mk(exp_q[i]));
            else n_pass++;
            step();
        end
        n_total++;
        if (bus.Head_Valid[0] !== 1'b0 || bus.Overflow_Err !== 1'b1)
            $display("FAIL ovf_end got=%b/%b exp=0/1",
                     bus.Head_Valid[0], bus.Overflow_Err);
        else n_pass++;
    endtask

    task automatic test_wrap_reset();
        bus.Valid_ID0_IB = 8'h40;
        bus.Valid_ID1_IB = 8'h40;
        bus.Entry_ID0_IB = mk(32'h61);
        bus.Entry_ID1_IB = mk(32'h62);
        step();
        bus.Issue_Grant  = 8'h40;
        bus.Valid_ID0_IB = 8'h40;
        bus.Entry_ID0_IB = mk(32'h63);
        #1;
        n_total++;
        if (bus.Issue_Entry !== mk(32'h61))
            $display("FAIL wrap_e1 got=%h exp=%h",
                     bus.Issue_Entry, mk(32'h61));
        else n_pass++;
        step();
        bus.Issue_Grant  = 8'h40;
        bus.Valid_ID0_IB = 8'h40;
        bus.Valid_ID1_IB = 8'h40;
        bus.Entry_ID0_IB = mk(32'h64);
        bus.Entry_ID1_IB = mk(32'h65);
        #1;
        n_total++;
        if (bus.Issue_Entry !== mk(32'h62))
            $display("FAIL wrap_e2 got=%h exp=%h",
                     bus.Issue_Entry, mk(32'h62));
        else n_pass++;
        step();
        bus.Issue_Grant  = 8'h40;
        bus.Valid_ID0_IB = 8'h40;
        bus.Entry_ID0_IB = mk(32'h66);
        #1;
        n_total++;
        if (bus.Issue_Entry !== mk(32'h63) || bus.Full_IB_IF[6] !== 1'b1)
            $display("FAIL wrap_e3 got=%h/%b exp=%h/1",
                     bus.Issue_Entry, bus.Full_IB_IF[6], mk(32'h63));
        else n_pass++;
        step();
        rst_n = 1'b0;
        bus.Issue_Grant = 8'h40;
        #1;
        n_total++;
        if (bus.Head_Valid !== 8'h00 || bus.Full_IB_IF !== 8'h00 ||
            bus.Overflow_Err !== 1'b0)
            $display("FAIL rst_mid got=%h/%h/%b exp=00/00/0",
                     bus.Head_Valid, bus.Full_IB_IF, bus.Overflow_Err);
        else n_pass++;
        n_total++;
        if (bus.Issue_Valid !== 1'b0 || bus.Issue_Entry !== 77'd0)
            $display("FAIL rst_mid_issue got=%b/%h exp=0/0",
                     bus.Issue_Valid, bus.Issue_Entry);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        bus.Issue_Grant = 8'h40;
        #1;
        n_total++;
        if (bus.Head_Valid !== 8'h00 || bus.Issue_Valid !== 1'b0)
            $display("FAIL rst_stale got=%h/%b exp=00/0",
                     bus.Head_Valid, bus.Issue_Valid);
        else n_pass++;
        step();
        bus.Valid_ID0_IB = 8'h40;
        bus.Entry_ID0_IB = mk(32'h67);
        step();
        bus.Issue_Grant = 8'h40;
        #1;
        n_total++;
        if (bus.Issue_Entry !== mk(32'h67))
            $display("FAIL rst_fresh got=%h exp=%h",
                     bus.Issue_Entry, mk(32'h67));
        else n_pass++;
        step();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_dual_lane();
        test_flush();
        test_grant_priority();
        test_overflow();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
